result_streamer: RTL

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : result_streamer
// Description : Snapshots an N x N signed result set from the systolic array
//               on done_in and streams it out element by element, row-major,
//               over a valid/ready interface. Tracks dropped sets with a
//               sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module result_streamer #(
    parameter int ARRAY_SIZE = 3,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         done_in,
    input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]  result_flat,
    input  logic                                         m_ready,
    input  logic                                         clear_overrun,
    output logic                                         m_valid,
    output logic signed [DATA_WIDTH-1:0]                 m_data,
    output logic [IDX_W-1:0]                             m_row,
    output logic [IDX_W-1:0]                             m_col,
    output logic                                         m_last,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int               c_NUM      = ARRAY_SIZE * ARRAY_SIZE;
    localparam int               c_KW       = $clog2(c_NUM);
    localparam logic [c_KW-1:0]  c_K_LAST   = c_KW'(c_NUM - 1);
    localparam logic [IDX_W-1:0] c_COL_LAST = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_KW-1:0]        k_q, k_d;
    logic [IDX_W-1:0]       row_q, row_d;
    logic [IDX_W-1:0]       col_q, col_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]  snap_q [0:c_NUM-1];

    logic                   w_xfer;
    logic                   w_at_last;
    logic                   w_capture;
    logic                   w_drop;

    // Valid comes straight from state, never from m_ready
    assign w_xfer    = (state_q == S_STREAM) && m_ready;
    assign w_at_last = (k_q == c_K_LAST);

    // Next-state, index stepping and capture/drop decisions
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        w_capture = 1'b0;
        w_drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (done_in) begin
                    w_capture = 1'b1;
                    state_d   = S_STREAM;
                    k_d       = '0;
                    row_d     = '0;
                    col_d     = '0;
                end
            end
            S_STREAM: begin
                if (w_xfer && w_at_last) begin
                    // A new set arriving with the final transfer chains on with no bubble
                    k_d   = '0;
                    row_d = '0;
                    col_d = '0;
                    if (done_in) begin
                        w_capture = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        k_d = k_q + c_KW'(1);
                        if (col_q == c_COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + IDX_W'(1);
                        end else begin
                            col_d = col_q + IDX_W'(1);
                        end
                    end
                    w_drop = done_in;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A drop in the same cycle as a clear keeps the flag set
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State, element index and overrun registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot buffer only loads on an accepted capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM; i++) begin
                snap_q[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < c_NUM; i++) begin
                snap_q[i] <= result_flat[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Outputs are forced to zero whenever nothing is being presented
    assign m_valid = (state_q == S_STREAM);
    assign busy    = m_valid;
    assign m_data  = m_valid ? $signed(snap_q[k_q]) : '0;
    assign m_row   = m_valid ? row_q : '0;
    assign m_col   = m_valid ? col_q : '0;
    assign m_last  = m_valid && w_at_last;
    assign overrun = overrun_q;

endmodule
`default_nettype wire
